sme_feeder: RTL and testbench

- Upstream stage of the string-matching engine (SME).
- Accepts string and pattern records from a host byte stream over a valid/ready handshake, and buffers them locally.
- Replays them to the SME using its isstring/ispattern/chardata protocol: string burst, then pattern burst, then both idle.
- Waits for the SME's valid pulse and latches match/match_index into a result register for the host.

---
 rtl/sme_pkg.sv | 27 ++
 rtl/sme_feeder_if.sv | 16 +
 rtl/sme_feeder_buf.sv | 37 +++
 rtl/sme_feeder.sv | 233 +++++++++++++++++++++++
 tb/tb_sme_feeder.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sme_pkg.sv
// sme_pkg: shared definitions for the SME feeder slice.
//   state_t      - feeder FSM states
//   CH_*         - SME pattern metacharacters
//   *_MAX_DEF    - default buffer depths
//   TO_INDEX     - match index reported when the result wait times out
package sme_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND_STR,
    ST_SEND_PAT,
    ST_WAIT_RES
  } state_t;

  localparam logic [7:0] CH_CARET  = 8'h5E;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_DOT    = 8'h2E;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_SPACE  = 8'h20;

  localparam int STR_MAX_DEF = 32;
  localparam int PAT_MAX_DEF = 8;

  localparam logic [4:0] TO_INDEX = 5'h1F;

endpackage

// File: rtl/sme_feeder_if.sv
// sme_feeder_if: host byte-stream handshake into the feeder.
//   in_valid/in_ready - valid/ready handshake
//   in_data           - record byte
//   in_kind           - 0 string, 1 pattern (first byte of a record only)
//   in_last           - final byte of the record
// Modports: master (host side), slave (feeder side).
interface sme_feeder_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_kind;
  logic       in_last;

  modport master (output in_valid, in_data, in_kind, in_last, input in_ready);
  modport slave  (input in_valid, in_data, in_kind, in_last, output in_ready);
endinterface

// File: rtl/sme_feeder_buf.sv
// sme_feeder_buf: byte RAM with one write port, one asynchronous read port
// and a record-length register.
//   clk, reset        - clock, async active-low reset (length only)
//   we/waddr/wdata    - byte write
//   raddr/rdata       - combinational byte read
//   len_we/len_in/len - record length register
module sme_feeder_buf #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH),
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata,
  input  logic          len_we,
  input  logic [LW-1:0] len_in,
  output logic [LW-1:0] len
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      len <= '0;
    else if (len_we) len <= len_in;
  end

endmodule

// File: rtl/sme_feeder.sv
// sme_feeder: collects string/pattern records from the host, replays them
// to the SME (string burst then pattern burst) and latches the SME result.
//   clk, reset                        - clock, async active-low reset
//   host (sme_feeder_if.slave)        - host record byte stream
//   chardata/isstring/ispattern       - registered SME feed
//   sme_valid/sme_match/sme_index     - SME result
//   res_valid/res_match/res_index     - latched result, res_valid pulses
//   busy                              - replaying or awaiting a result
//   ovf_err, seq_err                  - sticky record errors
// Optional: SME_FEEDER_TIMEOUT_EN adds TO_CYCLES and a to_err port; the
// result wait then gives up after TO_CYCLES cycles.
module sme_feeder
  import sme_pkg::*;
#(
  parameter int STR_MAX = STR_MAX_DEF,
  parameter int PAT_MAX = PAT_MAX_DEF
`ifdef SME_FEEDER_TIMEOUT_EN
  , parameter int TO_CYCLES = 255
`endif
) (
  input  logic       clk,
  input  logic       reset,
  sme_feeder_if.slave host,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       sme_valid,
  input  logic       sme_match,
  input  logic [4:0] sme_index,
  output logic       res_valid,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic       busy,
  output logic       ovf_err,
  output logic       seq_err
`ifdef SME_FEEDER_TIMEOUT_EN
  , output logic     to_err
`endif
);

  localparam int CW  = $clog2(STR_MAX + 1);
  localparam int SAW = $clog2(STR_MAX);
  localparam int PAW = $clog2(PAT_MAX);
  localparam int SLW = $clog2(STR_MAX + 1);
  localparam int PLW = $clog2(PAT_MAX + 1);

  state_t          state, state_n;
  logic            kind, kind_n, cur_kind;
  logic [CW-1:0]   count, count_n, base, cnt_inc, max_cur;
  logic [CW-1:0]   sidx, sidx_n;
  logic            str_new, str_new_n, ovf_n, seq_n, accept, fits;
  logic            str_we, pat_we, str_len_we, pat_len_we;
  logic [SLW-1:0]  str_len;
  logic [PLW-1:0]  pat_len;
  logic [SAW-1:0]  str_raddr;
  logic [PAW-1:0]  pat_raddr;
  logic [7:0]      str_rdata, pat_rdata, chardata_n;
  logic            isstring_n, ispattern_n, res_valid_n, res_match_n;
  logic [4:0]      res_index_n;
`ifdef SME_FEEDER_TIMEOUT_EN
  localparam int TW = $clog2(TO_CYCLES + 1);
  logic [TW-1:0]   tcnt, tcnt_n;
  logic            to_err_n;
`endif

  assign host.in_ready = reset && (state == ST_IDLE || state == ST_LOAD);
  assign busy          = (state == ST_SEND_STR) || (state == ST_SEND_PAT) ||
                         (state == ST_WAIT_RES);
  assign accept        = host.in_valid && host.in_ready;
  assign cur_kind      = (state == ST_IDLE) ? host.in_kind : kind;
  assign max_cur       = cur_kind ? CW'(PAT_MAX) : CW'(STR_MAX);
  assign base          = (state == ST_IDLE) ? '0 : count;
  assign fits          = base < max_cur;
  assign cnt_inc       = fits ? base + CW'(1) : base;
  assign str_we        = accept && !cur_kind && fits;
  assign pat_we        = accept && cur_kind && fits;
  assign str_raddr     = (state == ST_SEND_STR) ? sidx[SAW-1:0] : '0;
  assign pat_raddr     = (state == ST_SEND_PAT) ? sidx[PAW-1:0] : '0;

  sme_feeder_buf #(.DEPTH(STR_MAX), .AW(SAW), .LW(SLW)) u_str_buf (
    .clk(clk), .reset(reset), .we(str_we), .waddr(base[SAW-1:0]),
    .wdata(host.in_data), .raddr(str_raddr), .rdata(str_rdata),
    .len_we(str_len_we), .len_in(SLW'(cnt_inc)), .len(str_len)
  );

  sme_feeder_buf #(.DEPTH(PAT_MAX), .AW(PAW), .LW(PLW)) u_pat_buf (
    .clk(clk), .reset(reset), .we(pat_we), .waddr(base[PAW-1:0]),
    .wdata(host.in_data), .raddr(pat_raddr), .rdata(pat_rdata),
    .len_we(pat_len_we), .len_in(PLW'(cnt_inc)), .len(pat_len)
  );

  // The SME feed is registered, so each branch precomputes the byte to be
  // shown next cycle; sidx is the index of the byte after the one loaded.
  always_comb begin
    state_n     = state;
    kind_n      = kind;
    count_n     = count;
    sidx_n      = sidx;
    str_new_n   = str_new;
    ovf_n       = ovf_err;
    seq_n       = seq_err;
    str_len_we  = 1'b0;
    pat_len_we  = 1'b0;
    chardata_n  = '0;
    isstring_n  = 1'b0;
    ispattern_n = 1'b0;
    res_valid_n = 1'b0;
    res_match_n = res_match;
    res_index_n = res_index;
`ifdef SME_FEEDER_TIMEOUT_EN
    tcnt_n      = tcnt;
    to_err_n    = to_err;
`endif
    case (state)
      ST_IDLE, ST_LOAD: begin
        if (accept) begin
          kind_n  = cur_kind;
          count_n = cnt_inc;
          if (!fits) ovf_n = 1'b1;
          if (!host.in_last) begin
            state_n = ST_LOAD;
          end else if (!cur_kind) begin
            str_len_we = 1'b1;
            str_new_n  = 1'b1;
            state_n    = ST_IDLE;
          end else if (str_len == '0) begin
            seq_n   = 1'b1;
            state_n = ST_IDLE;
          end else begin
            pat_len_we = 1'b1;
            sidx_n     = CW'(1);
            if (str_new) begin
              state_n    = ST_SEND_STR;
              isstring_n = 1'b1;
              chardata_n = str_rdata;
            end else begin
              state_n     = ST_SEND_PAT;
              ispattern_n = 1'b1;
              // A one-byte pattern is being written this very cycle.
              chardata_n  = (state == ST_IDLE) ? host.in_data : pat_rdata;
            end
          end
        end
      end
      ST_SEND_STR: begin
        if (sidx < CW'(str_len)) begin
          isstring_n = 1'b1;
          chardata_n = str_rdata;
          sidx_n     = sidx + CW'(1);
        end else begin
          str_new_n   = 1'b0;
          state_n     = ST_SEND_PAT;
          ispattern_n = 1'b1;
          chardata_n  = pat_rdata;
          sidx_n      = CW'(1);
        end
      end
      ST_SEND_PAT: begin
        if (sidx < CW'(pat_len)) begin
          ispattern_n = 1'b1;
          chardata_n  = pat_rdata;
          sidx_n      = sidx + CW'(1);
        end else begin
          state_n = ST_WAIT_RES;
`ifdef SME_FEEDER_TIMEOUT_EN
          tcnt_n  = '0;
`endif
        end
      end
      ST_WAIT_RES: begin
        if (sme_valid) begin
          res_valid_n = 1'b1;
          res_match_n = sme_match;
          res_index_n = sme_index;
          state_n     = ST_IDLE;
        end
`ifdef SME_FEEDER_TIMEOUT_EN
        else if (tcnt == TW'(TO_CYCLES - 1)) begin
          res_valid_n = 1'b1;
          res_match_n = 1'b0;
          res_index_n = TO_INDEX;
          to_err_n    = 1'b1;
          state_n     = ST_IDLE;
        end else begin
          tcnt_n = tcnt + TW'(1);
        end
`endif
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      kind      <= 1'b0;
      count     <= '0;
      sidx      <= '0;
      str_new   <= 1'b0;
      ovf_err   <= 1'b0;
      seq_err   <= 1'b0;
      chardata  <= '0;
      isstring  <= 1'b0;
      ispattern <= 1'b0;
      res_valid <= 1'b0;
      res_match <= 1'b0;
      res_index <= '0;
`ifdef SME_FEEDER_TIMEOUT_EN
      tcnt      <= '0;
      to_err    <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      kind      <= kind_n;
      count     <= count_n;
      sidx      <= sidx_n;
      str_new   <= str_new_n;
      ovf_err   <= ovf_n;
      seq_err   <= seq_n;
      chardata  <= chardata_n;
      isstring  <= isstring_n;
      ispattern <= ispattern_n;
      res_valid <= res_valid_n;
      res_match <= res_match_n;
      res_index <= res_index_n;
`ifdef SME_FEEDER_TIMEOUT_EN
      tcnt      <= tcnt_n;
      to_err    <= to_err_n;
`endif
    end
  end

endmodule

// File: tb/tb_sme_feeder.sv
// tb_sme_feeder: directed bench for sme_feeder with a record-level model
// of the expected SME feed, busy/ready and result/error outputs.
module tb_sme_feeder;
  import sme_pkg::*;

  localparam int SMAX = 32;
  localparam int PMAX = 8;
  localparam int TO   = 255;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] chardata;
  logic       isstring, ispattern;
  logic       sme_valid, sme_match;
  logic [4:0] sme_index;
  logic       res_valid, res_match;
  logic [4:0] res_index;
  logic       busy, ovf_err, seq_err;
`ifdef SME_FEEDER_TIMEOUT_EN
  logic       to_err;
`endif

  sme_feeder_if hif ();

  sme_feeder dut (
    .clk(clk), .reset(reset), .host(hif),
    .chardata(chardata), .isstring(isstring), .ispattern(ispattern),
    .sme_valid(sme_valid), .sme_match(sme_match), .sme_index(sme_index),
    .res_valid(res_valid), .res_match(res_match), .res_index(res_index),
    .busy(busy), .ovf_err(ovf_err), .seq_err(seq_err)
`ifdef SME_FEEDER_TIMEOUT_EN
    , .to_err(to_err)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  logic [7:0] rec[$];
  logic [7:0] mstr[$];
  logic       rec_kind, in_rec, mstr_new;
  logic       movf, mseq, mto, mwait, pend_res, mres_match;
  logic [4:0] mres_index;
  int         wcnt;
  logic       q_kind[$];
  logic [7:0] q_byte[$];

  always @(negedge clk) begin
    logic popped, waitnow, bexp, k;
    logic [7:0] b;
    if (!reset) begin
      rec.delete(); mstr.delete(); q_kind.delete(); q_byte.delete();
      rec_kind = 0; in_rec = 0; mstr_new = 0; movf = 0; mseq = 0; mto = 0;
      mwait = 0; pend_res = 0; mres_match = 0; mres_index = '0; wcnt = 0;
    end else begin
      popped = 1'b0;
      if (q_byte.size() > 0) begin
        popped = 1'b1;
        k = q_kind.pop_front();
        b = q_byte.pop_front();
        check("isstring", isstring, k ? 0 : 1);
        check("ispattern", ispattern, k);
        check("chardata", chardata, b);
      end else begin
        check("isstring_idle", isstring, 0);
        check("ispattern_idle", ispattern, 0);
      end
      waitnow = !popped && mwait;
      bexp = popped || waitnow;
      check("busy", busy, bexp);
      check("in_ready", hif.in_ready, !bexp);
      check("res_valid", res_valid, pend_res);
      check("res_match", res_match, mres_match);
      check("res_index", res_index, mres_index);
      check("ovf_err", ovf_err, movf);
      check("seq_err", seq_err, mseq);
`ifdef SME_FEEDER_TIMEOUT_EN
      check("to_err", to_err, mto);
`endif
      pend_res = 0;
      if (waitnow) begin
        if (sme_valid) begin
          pend_res = 1; mres_match = sme_match; mres_index = sme_index; mwait = 0;
        end else begin
          wcnt++;
`ifdef SME_FEEDER_TIMEOUT_EN
          if (wcnt == TO) begin
            pend_res = 1; mres_match = 0; mres_index = 5'h1F; mto = 1; mwait = 0;
          end
`endif
        end
      end
      if (hif.in_valid && hif.in_ready) begin
        if (!in_rec) begin
          rec_kind = hif.in_kind; rec.delete(); in_rec = 1;
        end
        if (rec.size() < (rec_kind ? PMAX : SMAX)) rec.push_back(hif.in_data);
        else movf = 1;
        if (hif.in_last) begin
          in_rec = 0;
          if (!rec_kind) begin
            mstr = rec; mstr_new = 1;
          end else if (mstr.size() == 0) begin
            mseq = 1;
          end else begin
            if (mstr_new) foreach (mstr[i]) begin q_kind.push_back(0); q_byte.push_back(mstr[i]); end
            foreach (rec[i]) begin q_kind.push_back(1); q_byte.push_back(rec[i]); end
            mstr_new = 0; mwait = 1; wcnt = 0;
          end
        end
      end
    end
  end

  // Raw capture of what the DUT actually strobed, for literal checks.
  logic [7:0] seen_s[$];
  logic [7:0] seen_p[$];
  always @(negedge clk) begin
    if (isstring)  seen_s.push_back(chardata);
    if (ispattern) seen_p.push_back(chardata);
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_rec(input logic k, input logic [7:0] d[$], input int gap);
    int n;
    for (int i = 0; i < d.size(); i++) begin
      if (gap > 0 && i > 0) begin
        hif.in_valid = 0;
        repeat (gap) tick();
      end
      hif.in_valid = 1;
      hif.in_data  = d[i];
      hif.in_kind  = (i == 0) ? k : ~k;
      hif.in_last  = (i == d.size() - 1);
      n = 0;
      while (!hif.in_ready && n < 200) begin tick(); n++; end
      if (n >= 200) check("ready_timeout", 1, 0);
      tick();
    end
    hif.in_valid = 0;
    hif.in_last  = 0;
  endtask

  task automatic wait_res_state();
    int n = 0;
    while (!(busy && !isstring && !ispattern) && n < 200) begin tick(); n++; end
    if (n >= 200) check("wait_res_timeout", 1, 0);
  endtask

  task automatic pulse_sme(input logic m, input logic [4:0] idx);
    sme_valid = 1; sme_match = m; sme_index = idx;
    tick();
    sme_valid = 0; sme_match = 0; sme_index = '0;
  endtask

  task automatic wait_res_valid(input int lim);
    int n = 0;
    while (!res_valid && n < lim) begin tick(); n++; end
    if (n >= lim) check("res_valid_timeout", 1, 0);
  endtask

  task automatic clear_seen();
    seen_s.delete();
    seen_p.delete();
  endtask

  logic [7:0] d[$];

  initial begin
    reset = 0;
    hif.in_valid = 0; hif.in_data = '0; hif.in_kind = 0; hif.in_last = 0;
    sme_valid = 0; sme_match = 0; sme_index = '0;
    repeat (2) tick();
    check("rst_isstring", isstring, 0);
    check("rst_ispattern", ispattern, 0);
    check("rst_chardata", chardata, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", hif.in_ready, 0);
    reset = 1;
    tick();

    // Pattern with no string loaded: discarded, seq_err.
    clear_seen();
    d = {8'h78};
    send_rec(1, d, 0);
    tick();
    check("seq_err_set", seq_err, 1);
    check("seq_no_strobe", seen_s.size() + seen_p.size(), 0);
    check("seq_ready", hif.in_ready, 1);

    // "abc" then "bc".
    clear_seen();
    d = {8'h61, 8'h62, 8'h63};
    send_rec(0, d, 0);
    d = {8'h62, 8'h63};
    send_rec(1, d, 0);
    wait_res_state();
    check("abc_len", seen_s.size(), 3);
    check("abc_0", seen_s[0], 8'h61);
    check("abc_2", seen_s[2], 8'h63);
    check("bc_len", seen_p.size(), 2);
    check("bc_0", seen_p[0], 8'h62);
    check("bc_1", seen_p[1], 8'h63);
    pulse_sme(1, 5'd1);
    wait_res_valid(20);
    check("abc_res_match", res_match, 1);
    check("abc_res_index", res_index, 1);

    // Pattern only, replayed against the retained string.
    clear_seen();
    d = {CH_CARET, 8'h61};
    send_rec(1, d, 0);
    wait_res_state();
    check("caret_no_str", seen_s.size(), 0);
    check("caret_len", seen_p.size(), 2);
    check("caret_0", seen_p[0], 8'h5E);
    check("caret_1", seen_p[1], 8'h61);
    pulse_sme(1, 5'd0);
    wait_res_valid(20);

    // Gapped load; early sme_valid during pattern burst must be ignored.
    clear_seen();
    d = {8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F};
    send_rec(0, d, 1);
    d = {8'h6C, 8'h6F};
    send_rec(1, d, 1);
    begin
      int n = 0;
      while (!ispattern && n < 50) begin tick(); n++; end
      if (n >= 50) check("ispattern_timeout", 1, 0);
    end
    pulse_sme(1, 5'd7);
    wait_res_state();
    pulse_sme(0, 5'd3);
    wait_res_valid(20);
    check("gap_str_len", seen_s.size(), 5);
    check("gap_str_4", seen_s[4], 8'h6F);
    check("gap_pat_len", seen_p.size(), 2);
    check("gap_res_match", res_match, 0);
    check("gap_res_index", res_index, 3);

    // Overflow: 34-byte string, 9-byte pattern.
    clear_seen();
    d.delete();
    for (int i = 0; i < 34; i++) d.push_back(8'h41 + 8'(i));
    send_rec(0, d, 0);
    d.delete();
    for (int i = 0; i < 9; i++) d.push_back(8'h30 + 8'(i));
    send_rec(1, d, 0);
    wait_res_state();
    check("ovf_str_len", seen_s.size(), 32);
    check("ovf_str_31", seen_s[31], 8'h60);
    check("ovf_pat_len", seen_p.size(), 8);
    check("ovf_pat_7", seen_p[7], 8'h37);
    check("ovf_flag", ovf_err, 1);
    pulse_sme(0, 5'd2);
    wait_res_valid(20);

    // Reset mid string burst.
    d = {8'h77, 8'h78, 8'h79, 8'h7A};
    send_rec(0, d, 0);
    d = {8'h79, 8'h7A};
    send_rec(1, d, 0);
    check("mid_isstring_pre", isstring, 1);
    tick();
    reset = 0;
    #1;
    check("mid_isstring", isstring, 0);
    check("mid_ispattern", ispattern, 0);
    check("mid_chardata", chardata, 0);
    check("mid_busy", busy, 0);
    check("mid_ovf", ovf_err, 0);
    tick();
    tick();
    reset = 1;
    tick();
    clear_seen();
    d = {8'h70, 8'h71};
    send_rec(0, d, 0);
    d = {8'h71};
    send_rec(1, d, 0);
    wait_res_state();
    check("post_str_len", seen_s.size(), 2);
    check("post_str_1", seen_s[1], 8'h71);
    check("post_pat_len", seen_p.size(), 1);
    check("post_pat_0", seen_p[0], 8'h71);
    pulse_sme(1, 5'd1);
    wait_res_valid(20);

`ifdef SME_FEEDER_TIMEOUT_EN
    d = {8'h61, 8'h62};
    send_rec(0, d, 0);
    d = {8'h62};
    send_rec(1, d, 0);
    wait_res_state();
    wait_res_valid(400);
    check("to_res_index", res_index, 5'h1F);
    check("to_res_match", res_match, 0);
    check("to_err", to_err, 1);
`endif

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
